// File: rtl/imm_rotate_encoder.sv
// Iterative search for the ARM {rotate, imm8} immediate encoding of a 32-bit constant.
// Optional MOV/MVN second pass on ~value is built when IMM_ENC_INVERT_FALLBACK_EN is defined.
module imm_rotate_encoder #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH-1:0]            in_value,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_encodable,
  output logic                             out_inverted,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state;
  logic [3:0]            idx;
  logic [WORD_WIDTH-1:0] captured;
  logic [4:0]            rot_amt;
  logic [WORD_WIDTH-1:0] candidate;
  logic                  match;

  // Rotating left by 2*idx undoes the ROR applied when the immediate is expanded.
  always_comb begin
    rot_amt   = {idx, 1'b0};
    candidate = WORD_WIDTH'(({captured, captured} << rot_amt) >> WORD_WIDTH);
    match     = (candidate[WORD_WIDTH-1:8] == '0);
  end

  assign in_ready = (state == IDLE);

`ifdef IMM_ENC_INVERT_FALLBACK_EN
  logic inverted;
`else
  assign out_inverted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 4'd0;
      captured        <= '0;
      out_valid       <= 1'b0;
      out_encodable   <= 1'b0;
      shifter_operand <= '0;
`ifdef IMM_ENC_INVERT_FALLBACK_EN
      inverted        <= 1'b0;
      out_inverted    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            captured <= in_value;
            idx      <= 4'd0;
            state    <= SEARCH;
`ifdef IMM_ENC_INVERT_FALLBACK_EN
            inverted <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (match) begin
            shifter_operand <= SHIFTER_OPERAND_WIDTH'({idx, candidate[7:0]});
            out_encodable   <= 1'b1;
            out_valid       <= 1'b1;
            state           <= DONE;
`ifdef IMM_ENC_INVERT_FALLBACK_EN
            out_inverted    <= inverted;
`endif
          end else if (idx != 4'd15) begin
            idx <= idx + 4'd1;
          end else begin
`ifdef IMM_ENC_INVERT_FALLBACK_EN
            // Direct pass exhausted: retry on the complement before giving up.
            if (!inverted) begin
              captured <= ~captured;
              idx      <= 4'd0;
              inverted <= 1'b1;
            end else begin
              shifter_operand <= '0;
              out_encodable   <= 1'b0;
              out_inverted    <= 1'b0;
              out_valid       <= 1'b1;
              state           <= DONE;
            end
`else
            shifter_operand <= '0;
            out_encodable   <= 1'b0;
            out_valid       <= 1'b1;
            state           <= DONE;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Directed self-checking bench for imm_rotate_encoder; expectations follow
// IMM_ENC_INVERT_FALLBACK_EN when the bench is built with that macro.
module tb_imm_rotate_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_encodable;
  logic        out_inverted;
  logic [11:0] shifter_operand;

  int compared;
  int mismatched;

  imm_rotate_encoder #(.WORD_WIDTH(32), .SHIFTER_OPERAND_WIDTH(12)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_encodable(out_encodable),
    .out_inverted(out_inverted),
    .shifter_operand(shifter_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one request, measures accept-to-out_valid edges, checks the result and the handshake.
  task automatic applyStimulus(input logic [31:0] value, input int exp_latency,
                               input logic exp_enc, input logic exp_inv, input logic [11:0] exp_op);
    int latency;
    latency = 0;
    @(negedge clk);
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = value;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 32'hDEAD_BEEF;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        latency = e;
        break;
      end
    end
    $display("[TB] value 0x%08h latency %0d", value, latency);
    checkOutput("latency", 32'(latency), 32'(exp_latency));
    checkOutput("encodable", 32'(out_encodable), 32'(exp_enc));
    checkOutput("inverted", 32'(out_inverted), 32'(exp_inv));
    checkOutput("shifter_operand", 32'(shifter_operand), 32'(exp_op));
    checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("out_valid_after_handshake", 32'(out_valid), 32'd0);
    checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_value   = 32'h0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_encodable", 32'(out_encodable), 32'd0);
    checkOutput("reset_inverted", 32'(out_inverted), 32'd0);
    checkOutput("reset_operand", 32'(shifter_operand), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h0000_0000, 1, 1'b1, 1'b0, 12'h000);
    applyStimulus(32'h0000_00FF, 1, 1'b1, 1'b0, 12'h0FF);
    applyStimulus(32'h0000_0004, 1, 1'b1, 1'b0, 12'h004);
    applyStimulus(32'hFF00_0000, 5, 1'b1, 1'b0, 12'h4FF);
    applyStimulus(32'h00AB_0000, 9, 1'b1, 1'b0, 12'h8AB);
    applyStimulus(32'h0000_03FC, 16, 1'b1, 1'b0, 12'hFFF);
`ifdef IMM_ENC_INVERT_FALLBACK_EN
    applyStimulus(32'h0000_0101, 32, 1'b0, 1'b0, 12'h000);
    applyStimulus(32'hFFFF_FF00, 17, 1'b1, 1'b1, 12'h0FF);
`else
    applyStimulus(32'h0000_0101, 16, 1'b0, 1'b0, 12'h000);
    applyStimulus(32'hFFFF_FF00, 16, 1'b0, 1'b0, 12'h000);
`endif

    // Reset in the middle of a search must abort it without any output.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'h0000_03FC;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_encodable", 32'(out_encodable), 32'd0);
    checkOutput("midreset_operand", 32'(shifter_operand), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      checkOutput("no_output_after_abort", 32'(seen), 32'd0);
    end

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'hFF00_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_value = 32'h0000_00FF;
    begin
      int latency;
      latency = 0;
      for (int e = 1; e <= 40; e++) begin
        @(posedge clk);
        #1;
        if (out_valid) begin
          latency = e;
          break;
        end
      end
      checkOutput("bp_latency", 32'(latency), 32'd5);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid_held", 32'(out_valid), 32'd1);
      checkOutput("bp_operand_held", 32'(shifter_operand), 32'h4FF);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
- Inverse of the datapath's Val2 immediate expansion. Takes a 32-bit constant and searches for the ARM data-processing immediate encoding {rotate[3:0], imm8[7:0]} such that value == ROR(imm8, 2*rotate).
- Iterative: tests one rotation candidate per clock and exits on the first match.
- Sits in the instruction-build/test-support path next to the decode stage and feeds the 12-bit shifter_operand field.

Parameters:
- WORD_WIDTH, 32, data word width. Fixed by the codebase; the encoding assumes 32.
- SHIFTER_OPERAND_WIDTH, 12, width of the encoded operand field.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_value  input  WORD_WIDTH  constant to encode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_encodable  output  1  1 = encoding found.
- out_inverted  output  1  1 = encoding is of ~in_value. Constant 0 without the optional feature.
- shifter_operand  output  SHIFTER_OPERAND_WIDTH  {rotate, imm8}; 0 when not encodable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, in_ready=1.
  - out_valid=0, out_encodable=0, out_inverted=0, shifter_operand=0.
  - Captured value cleared.
  - Reset mid-search aborts the request with no output. Recovery takes effect the first edge after rst_n rises.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: capture in_value, idx=0, go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Each cycle tests candidate c = ROL(captured, 2*idx); match when c[31:8]==0.
  - On match at that edge: shifter_operand={idx[3:0], c[7:0]}, out_encodable=1, go to DONE.
  - On no match with idx<15: idx=idx+1.
  - On no match with idx==15: out_encodable=0, shifter_operand=0, go to DONE.
  - Smallest matching rotate always wins, so the encoding is canonical.
- DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - in_ready is 0 in DONE, so a new request cannot be accepted in the same cycle as the output handshake. Minimum spacing between accepts is 3 cycles.
- Latency, counted in edges after the accept edge:
  - Match at rotate k: out_valid high k+1 edges after accept (k=0 gives 1, k=15 gives 16).
  - Unencodable: 16.
- Arithmetic:
  - ROL is a 32-bit circular rotate; 2*idx ranges 0..30.
  - in_value=0 encodes as rotate=0, imm8=0 with latency 1.
- in_value is only sampled at accept; changes during SEARCH are ignored.
- in_valid held during SEARCH/DONE is not accepted until IDLE.

Optional Feature:
- Macro: IMM_ENC_INVERT_FALLBACK_EN.
- Defined:
  - When the direct search fails at idx==15, do not go to DONE. Instead re-capture ~value, set idx=0, set an internal inverted flag, and search again (MOV/MVN substitution).
  - A match in the second pass gives out_encodable=1, out_inverted=1.
  - A failure in the second pass gives out_encodable=0, out_inverted=0, shifter_operand=0, with worst-case latency 32.
  - The direct encoding always takes priority.
- Not defined: out_inverted is tied to 0 and the second pass is not built.

Test Plan:
- in_value=0x000000FF, out_ready=1 -> out_valid 1 edge after accept; encodable=1, shifter_operand=0x0FF.
- in_value=0xFF000000 -> latency 5; shifter_operand=0x4FF (rotate 4, imm8 0xFF).
- in_value=0x000003FC -> latency 16; shifter_operand=0xFFF (rotate 15, imm8 0xFF).
- in_value=0x00000101 -> latency 16; encodable=0, shifter_operand=0x000.
  - With IMM_ENC_INVERT_FALLBACK_EN: latency 32, encodable=0, inverted=0.
- With IMM_ENC_INVERT_FALLBACK_EN, in_value=0xFFFFFF00 -> latency 17; encodable=1, inverted=1, shifter_operand=0x0FF.
- Control: accept 0x3FC, pulse rst_n low at cycle 5 -> all outputs 0, in_ready=1, no out_valid. Then send 0xFF000000 with out_ready=0 for 4 cycles -> out_valid and 0x4FF held stable, in_ready=0. Raise out_ready -> IDLE on the next edge.
